// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: producer side of the IF->ID interface.
// Generates the fetch PC and issues instruction-memory requests within a credit
// limit. It buffers returned words in a small FIFO and presents instruction, outPC
// and fetch_valid to the IF/ID register every cycle. It also handles ID stall,
// branch/jump redirect and the discard of stale in-flight responses.
// Optional feature: define FETCH_ALIGN_CHECK_EN to add the misalign_err port.
// A misaligned redirect then halts fetch until reset. Without the macro, the low two
// redirect bits are ignored.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] outPC,
  output logic        fetch_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam int              PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]     DEPTH_V  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Circular-buffer pointer advance with wrap at the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  state_t          state_r;
  logic [31:0]     fetch_pc_r;
  logic [31:0]     rsp_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   fifo_count_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [31:0]     fifo_data_r [FIFO_DEPTH];
  logic [31:0]     fifo_pc_r   [FIFO_DEPTH];
  logic [31:0]     instr_r;
  logic [31:0]     pc_r;
  logic            valid_r;

  logic [31:0]     redirect_pc_s;
  logic            misalign_s;
  logic            redirect_take_s;
  logic            credit_ok_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            push_s;
  logic            pop_s;
  logic            wr_s;
  logic            rd_s;
  logic [31:0]     head_data_s;
  logic [31:0]     head_pc_s;
  logic [CW:0]     inflight_s;
  logic [CW:0]     redir_drop_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic            misalign_r;
  assign redirect_pc_s = redirect_pc;
  assign misalign_s    = (redirect_pc[1:0] != 2'b00);
  assign misalign_err  = misalign_r;
`else
  logic            unused_s;
  assign redirect_pc_s = {redirect_pc[31:2], 2'b00};
  assign misalign_s    = 1'b0;
  assign unused_s      = ^redirect_pc[1:0];
`endif

  // Redirects are ignored once halted; only reset leaves HALT.
  assign redirect_take_s = redirect_valid && (state_r != ST_HALT);

  // Credit covers both in-flight requests and words waiting in the buffer.
  assign credit_ok_s = ({1'b0, outstanding_r} + {1'b0, fifo_count_r}) < DEPTH_V;
  assign req_valid_s = (state_r == ST_FETCH) && credit_ok_s && !redirect_valid;
  assign req_fire_s  = req_valid_s && imem_req_ready;

  // A response is kept only when nothing stale is still owed and fetch is not halted.
  assign push_s = imem_rsp_valid && (drop_cnt_r == '0) && (state_r != ST_HALT);
  assign pop_s  = !stall && ((fifo_count_r != '0) || push_s);
  assign rd_s   = pop_s && (fifo_count_r != '0);
  assign wr_s   = push_s && !(pop_s && (fifo_count_r == '0)) && !redirect_take_s;

  assign inflight_s = {1'b0, outstanding_r} + {1'b0, drop_cnt_r};

  // Head selection (buffer head or bypassed response) and stale count at redirect.
  always_comb begin
    head_data_s  = imem_rsp_data;
    head_pc_s    = rsp_pc_r;
    redir_drop_s = inflight_s;
    if (fifo_count_r != '0) begin
      head_data_s = fifo_data_r[rd_ptr_r];
      head_pc_s   = fifo_pc_r[rd_ptr_r];
    end else begin
      head_data_s = imem_rsp_data;
      head_pc_s   = rsp_pc_r;
    end
    if (imem_rsp_valid && (inflight_s != '0)) begin
      redir_drop_s = inflight_s - (CW + 1)'(1);
    end else begin
      redir_drop_s = inflight_s;
    end
  end

  // Fetch FSM, PC and credit counters, FIFO pointers and the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
      fifo_count_r  <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      instr_r       <= NOP_INSN;
      pc_r          <= 32'h0000_0000;
      valid_r       <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_r    <= 1'b0;
`endif
    end else if (redirect_take_s) begin
      fetch_pc_r    <= redirect_pc_s;
      rsp_pc_r      <= redirect_pc_s;
      outstanding_r <= '0;
      drop_cnt_r    <= redir_drop_s[CW-1:0];
      fifo_count_r  <= '0;
      rd_ptr_r      <= '0;
      wr_ptr_r      <= '0;
      instr_r       <= NOP_INSN;
      valid_r       <= 1'b0;
      if (misalign_s) begin
        state_r <= ST_HALT;
      end else if (redir_drop_s != '0) begin
        state_r <= ST_FLUSH;
      end else begin
        state_r <= ST_FETCH;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_r    <= misalign_s;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_r    <= 1'b0;
`endif
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(push_s);
      if (imem_rsp_valid && (drop_cnt_r != '0)) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + 32'd4;
      end else begin
        rsp_pc_r <= rsp_pc_r;
      end
      if (wr_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      fifo_count_r <= fifo_count_r + CW'(wr_s) - CW'(rd_s);
      if (stall) begin
        instr_r <= instr_r;
        pc_r    <= pc_r;
        valid_r <= valid_r;
      end else if (pop_s) begin
        instr_r <= head_data_s;
        pc_r    <= head_pc_s;
        valid_r <= 1'b1;
      end else begin
        instr_r <= NOP_INSN;
        pc_r    <= pc_r;
        valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE:  state_r <= ST_FETCH;
        ST_FETCH: state_r <= ST_FETCH;
        ST_FLUSH: begin
          if ((drop_cnt_r == '0) || ((drop_cnt_r == CW'(1)) && imem_rsp_valid)) begin
            state_r <= ST_FETCH;
          end else begin
            state_r <= ST_FLUSH;
          end
        end
        ST_HALT:  state_r <= ST_HALT;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Response buffer storage: each entry holds a word and the PC it was fetched from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]   <= 32'h0000_0000;
      end
    end else if (wr_s) begin
      fifo_data_r[wr_ptr_r] <= imem_rsp_data;
      fifo_pc_r[wr_ptr_r]   <= rsp_pc_r;
    end else begin
      fifo_data_r <= fifo_data_r;
      fifo_pc_r   <= fifo_pc_r;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_addr      = fetch_pc_r;
  assign instruction    = instr_r;
  assign outPC          = pc_r;
  assign fetch_valid    = valid_r;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl. A memory model returns a word derived from each request
// address after a programmable latency. A stream model checks that every delivered
// word follows the fetch sequence from reset or from the latest redirect.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic [31:0] instruction;
  logic [31:0] outPC;
  logic        fetch_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .outPC(outPC), .fetch_valid(fetch_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  typedef struct { logic [31:0] addr; int due; int ep; } req_t;
  req_t        pend[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          lat = 1;
  int          last_due = 0;
  int          issued_since = 0;
  int          delivered_since = 0;
  int          idle = 0;
  int          max_idle = 0;
  logic [31:0] issue_pc = RESET_PC;
  logic [31:0] deliver_pc = RESET_PC;
  logic [31:0] m_pc = 32'h0;
  bit          m_valid = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          saw_valid = 1'b0;
  logic [31:0] first_pc = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC3C3_0001;
  endfunction

  function automatic int count_cur();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) n++;
    return n;
  endfunction

  function automatic int count_stale();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep != epoch) n++;
    return n;
  endfunction

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit stl, input bit rdv, input logic [31:0] rpc, input bit rdy);
    req_t r;
    int   d;
    // Outputs produced by the previous rising edge.
    if (prev_redirect) begin
      m_valid = 1'b0;
      idle = 0;
    end else if (!prev_stall) begin
      if (fetch_valid === 1'b1) begin
        m_valid = 1'b1;
        m_pc = deliver_pc;
        deliver_pc = deliver_pc + 32'd4;
        delivered_since++;
        idle = 0;
        if (!saw_valid) begin
          saw_valid = 1'b1;
          first_pc = outPC;
        end
      end else begin
        m_valid = 1'b0;
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
    end
    check_eq("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
    check_eq("outPC", outPC, m_pc);
    check_eq("instruction", instruction, m_valid ? word_of(m_pc) : NOP);
    // Memory response for this cycle.
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(r.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    stall = stl;
    redirect_valid = rdv;
    redirect_pc = rpc;
    imem_req_ready = rdy;
    #1;
    if (rdv) begin
      check_eq("req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
      epoch++;
      issue_pc = rpc & 32'hFFFF_FFFC;
      deliver_pc = rpc & 32'hFFFF_FFFC;
      issued_since = 0;
      delivered_since = 0;
    end else if (imem_req_valid === 1'b1 && rdy) begin
      check_eq("imem_addr", imem_addr, issue_pc);
      check_eq("issue_in_flush", count_stale(), 32'd0);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{issue_pc, d, epoch});
      issue_pc = issue_pc + 32'd4;
      issued_since++;
      check_eq("credit", {31'd0, (issued_since - delivered_since) <= DEPTH}, 32'd1);
    end
    prev_redirect = rdv;
    prev_stall = stl;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check_eq("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("rst_instruction", instruction, NOP);
    check_eq("rst_outPC", outPC, 32'h0);
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
    pend.delete();
    epoch++;
    issue_pc = RESET_PC;
    deliver_pc = RESET_PC;
    m_pc = 32'h0;
    m_valid = 1'b0;
    issued_since = 0;
    delivered_since = 0;
    last_due = cyc;
    prev_stall = 1'b0;
    prev_redirect = 1'b0;
    idle = 0;
    @(negedge clk);
    @(negedge clk);
    cyc += 2;
    last_due = cyc;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rp;
    int          guard;
    @(negedge clk);
    do_reset();

    // Sequential fetch from reset with single-cycle memory.
    lat = 1;
    saw_valid = 1'b0;
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t1_first_pc", first_pc, RESET_PC);
    check_eq("t1_progress", {31'd0, delivered_since >= 4}, 32'd1);

    // Three-cycle stall in mid-stream.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    guard = 0;
    while (count_cur() < 2 && guard < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      guard++;
    end
    check_eq("t3_two_inflight", count_cur(), 32'd2);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t3_first_pc", first_pc, 32'h0000_0100);

    // Address wrap at the top of the space.
    lat = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t4_first_pc", first_pc, 32'hFFFF_FFF8);
    check_eq("t4_wrap_progress", {31'd0, delivered_since >= 3}, 32'd1);

    // Reset while stale responses are still being flushed.
    lat = 3;
    guard = 0;
    while (count_cur() < 2 && guard < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    do_reset();
    lat = 1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("t5_restart_pc", first_pc, RESET_PC);

    // Randomized traffic: stalls, backpressure, redirects, varying latency.
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) lat = $urandom_range(1, 4);
      rp = $urandom;
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
`ifdef FETCH_ALIGN_CHECK_EN
      rp = rp & 32'hFFFF_FFFC;
`endif
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rp, $urandom_range(0, 3) != 0);
    end
    check_eq("max_idle_ok", {31'd0, max_idle <= 40}, 32'd1);

`ifdef FETCH_ALIGN_CHECK_EN
    begin : t6
      int reqs;
      reqs = 0;
      imem_rsp_valid = 1'b0;
      stall = 1'b0;
      imem_req_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
      #1;
      check_eq("t6_no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("t6_err_pulse", {31'd0, misalign_err}, 32'd1);
      @(negedge clk);
      check_eq("t6_err_clear", {31'd0, misalign_err}, 32'd0);
      for (int i = 0; i < 10; i++) begin
        #1;
        if (imem_req_valid === 1'b1) reqs++;
        @(negedge clk);
      end
      check_eq("t6_no_requests", reqs, 32'd0);
      check_eq("t6_bubble", {31'd0, fetch_valid}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
